// File: rtl/piso_shifter.sv
// -----------------------------------------------------------------------------
// piso_shifter
//   Parallel-in, serial-out shift register for the serial data leg of the 2:1
//   select stage. A WIDTH-bit word is taken over a valid/ready load handshake.
//   The word is then streamed one bit per accepted beat over a valid/ready
//   serial handshake. done pulses for one cycle after the last bit is accepted.
//
//   Parameters
//     WIDTH      data word width in bits (>= 2)
//     MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
//   Optional feature (macro PISO_PARITY_EN)
//     When defined, an even-parity bit follows the WIDTH data bits as one extra
//     beat. The parity bit is the XOR of the captured word.
//     When undefined, no parity bit is sent and there is no parity register.
//
//   Ports
//     clk         in   rising-edge clock
//     rst         in   asynchronous, active-high reset
//     load_valid  in   load_data is valid
//     load_ready  out  word can be accepted (IDLE only)
//     load_data   in   parallel word to serialise [WIDTH-1:0]
//     ser_ready   in   downstream accepts ser_out this cycle
//     ser_valid   out  ser_out carries a valid bit
//     ser_out     out  current serial bit (0 when ser_valid=0)
//     busy        out  high while a word is being shifted out
//     done        out  one-cycle pulse after the final bit is accepted
//
//   Every output comes from a register or is decoded from the state alone.
//   No input has a combinational path to any output.
// -----------------------------------------------------------------------------
module piso_shifter #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    count_reg;
  logic             done_reg;
  logic             beat;
  logic             last;
  logic             data_bit;
  logic             bit_sel;

`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  // A beat is an accepted serial transfer; ser_valid is simply "in SHIFT".
  assign beat = (state_reg == SHIFT) && ser_ready;
  assign last = (count_reg == CW'(NBITS - 1));

  // Shift toward the output end with zero fill.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shift_next[gi] = 1'b0;
        end else begin : g_move
          assign shift_next[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shift_next[gi] = 1'b0;
        end else begin : g_move
          assign shift_next[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_valid) state_next = SHIFT;
      SHIFT:   if (beat && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: shift register, beat counter, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= beat && last;
      // load_data is only sampled in IDLE; a load_valid while busy is ignored.
      if ((state_reg == IDLE) && load_valid) begin
        shreg_reg <= load_data;
        count_reg <= '0;
      end else if (beat) begin
        shreg_reg <= shift_next;
        count_reg <= count_reg + CW'(1);
      end
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is fixed at load time so the data register is free to shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if ((state_reg == IDLE) && load_valid) begin
      parity_reg <= ^load_data;
    end
  end
`endif

  assign data_bit = (MSB_FIRST != 0) ? shreg_reg[WIDTH-1] : shreg_reg[0];

`ifdef PISO_PARITY_EN
  // After WIDTH data beats the counter points at the parity slot.
  assign bit_sel = (count_reg == CW'(WIDTH)) ? parity_reg : data_bit;
`else
  assign bit_sel = data_bit;
`endif

  assign load_ready = (state_reg == IDLE);
  assign ser_valid  = (state_reg == SHIFT);
  assign busy       = (state_reg == SHIFT);
  assign ser_out    = (state_reg == SHIFT) && bit_sel;
  assign done       = done_reg;

endmodule

// File: tb/tb_piso_shifter.sv
// -----------------------------------------------------------------------------
// tb_piso_shifter
//   Drives one MSB-first and one LSB-first piso_shifter (WIDTH=8) with the
//   same inputs. A queue-based reference model holds the bits each instance
//   still has to send. Directed words come first, followed by randomized
//   traffic. The randomized traffic includes random stalls and random
//   load_valid pulses while a word is in flight.
// -----------------------------------------------------------------------------
module tb_piso_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         ser_ready = 1'b0;

  logic m_load_ready, m_ser_valid, m_ser_out, m_busy, m_done;
  logic l_load_ready, l_ser_valid, l_ser_out, l_busy, l_done;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit mdl_busy = 1'b0;
  bit mdl_done = 1'b0;
  bit q_msb[$];
  bit q_lsb[$];

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(m_load_ready), .load_data(load_data),
    .ser_ready(ser_ready), .ser_valid(m_ser_valid), .ser_out(m_ser_out),
    .busy(m_busy), .done(m_done)
  );

  piso_shifter #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(l_load_ready), .load_data(load_data),
    .ser_ready(ser_ready), .ser_valid(l_ser_valid), .ser_out(l_ser_out),
    .busy(l_busy), .done(l_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit em;
    bit el;
    em = mdl_busy ? q_msb[0] : 1'b0;
    el = mdl_busy ? q_lsb[0] : 1'b0;
    chk("msb.load_ready", m_load_ready, !mdl_busy);
    chk("msb.ser_valid",  m_ser_valid,  mdl_busy);
    chk("msb.busy",       m_busy,       mdl_busy);
    chk("msb.ser_out",    m_ser_out,    em);
    chk("msb.done",       m_done,       mdl_done);
    chk("lsb.load_ready", l_load_ready, !mdl_busy);
    chk("lsb.ser_valid",  l_ser_valid,  mdl_busy);
    chk("lsb.busy",       l_busy,       mdl_busy);
    chk("lsb.ser_out",    l_ser_out,    el);
    chk("lsb.done",       l_done,       mdl_done);
  endtask

  // Model of one clock edge: the word is a list of bits to emit, and done
  // follows the edge that empties the list.
  task automatic model_edge(input logic lv, input logic [W-1:0] ld, input logic sr);
    bit nd;
    nd = 1'b0;
    if (mdl_busy) begin
      if (sr) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
        if (q_msb.size() == 0) begin
          mdl_busy = 1'b0;
          nd = 1'b1;
        end
      end
    end else if (lv) begin
      for (int i = W - 1; i >= 0; i--) q_msb.push_back(ld[i]);
      for (int i = 0; i < W; i++) q_lsb.push_back(ld[i]);
`ifdef PISO_PARITY_EN
      q_msb.push_back(^ld);
      q_lsb.push_back(^ld);
`endif
      mdl_busy = 1'b1;
    end
    mdl_done = nd;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model and the clock.
  task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic sr);
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    #1;
    check_outputs();
    model_edge(lv, ld, sr);
    @(posedge clk);
    #1;
  endtask

  // Load a word and stream it out. An optional stall starts after a given
  // number of beats. An optional busy load of 8'hFF is poked mid-word.
  task automatic send(input logic [W-1:0] w, input int stall_after,
                      input int stall_len, input bit poke);
    int beats;
    int stalled;
    beats = 0;
    stalled = 0;
    cycle(1'b1, w, 1'b1);
    for (int n = 0; n < 64 && mdl_busy; n++) begin
      if (beats == stall_after && stalled < stall_len) begin
        cycle(poke, 8'hFF, 1'b0);
        stalled++;
      end else begin
        cycle(poke && (beats >= 3) && (beats <= 4), 8'hFF, 1'b1);
        beats++;
      end
    end
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    q_msb.delete();
    q_lsb.delete();
    mdl_busy = 1'b0;
    mdl_done = 1'b0;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0);

    // Straight word, then a load on the very cycle done is high.
    send(8'hA5, -1, 0, 1'b0);
    send(8'h01, -1, 0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Three-cycle stall after two bits.
    send(8'hF0, 2, 3, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // load_valid pulsed with 8'hFF while busy must be ignored.
    send(8'hC3, -1, 0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Reset after four bits of 8'h3C, then a fresh word.
    cycle(1'b1, 8'h3C, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    async_reset();
    cycle(1'b0, '0, 1'b1);
    send(8'h81, -1, 0, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // Parity-sensitive words (odd and even weight).
    send(8'h07, -1, 0, 1'b0);
    send(8'h03, -1, 0, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      repeat ($urandom_range(0, 2)) cycle(1'b0, W'($urandom), 1'($urandom));
      cycle(1'b1, w, 1'($urandom));
      for (int n = 0; n < 200 && mdl_busy; n++) begin
        cycle(1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom_range(0, 2) != 0));
      end
    end
    repeat (2) cycle(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
